// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_pkg: RV32I opcodes, immediate kinds, ID/EX payload. Rev 1.0      |
// +----------------------------------------------------------------------+
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic              is_load;
  } idex_t;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      OPC_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OPC_BRANCH, OPC_STORE, OPC_OP: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_gen: combinational RV32I immediate extraction. Rev 1.0            |
// +----------------------------------------------------------------------+
module imm_gen
  import core_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_type_of(instr[6:0]))
      IMM_I:   imm = {{21{instr[31]}}, instr[30:20]};
      IMM_S:   imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_stage: RV32I decode + ID/EX register with load-use stall. Rev 1.0  |
// | Optional macro ID_BYPASS_EN: same-cycle WB write-through to operands. |
// +----------------------------------------------------------------------+
module id_stage
  import core_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  input  logic [DW-1:0] if_instr,
  input  logic [DW-1:0] if_pc,
  output logic          id_ready,
  output logic [AW-1:0] rf_rd_addr1,
  output logic [AW-1:0] rf_rd_addr2,
  input  logic [DW-1:0] rf_rd_data1,
  input  logic [DW-1:0] rf_rd_data2,
  input  logic          wb_wr_en,
  input  logic [AW-1:0] wb_wr_addr,
  input  logic [DW-1:0] wb_wr_data,
  input  logic          flush,
  input  logic          ex_ready,
  output logic          ex_valid,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_instr,
  output logic [DW-1:0] ex_rs1_data,
  output logic [DW-1:0] ex_rs2_data,
  output logic [DW-1:0] ex_imm,
  output logic [AW-1:0] ex_rs1,
  output logic [AW-1:0] ex_rs2,
  output logic [AW-1:0] ex_rd,
  output logic          ex_rd_we,
  output logic          ex_is_load
);

  logic [6:0]    opcode;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [AW-1:0] rd;
  logic [DW-1:0] rs1_val;
  logic [DW-1:0] rs2_val;
  logic [DW-1:0] imm;
  logic          hazard;
  logic          capture;
  logic          valid_q;
  idex_t         payload_q;
  idex_t         payload_d;

  assign opcode      = if_instr[6:0];
  assign rd          = if_instr[11:7];
  assign rs1         = if_instr[19:15];
  assign rs2         = if_instr[24:20];
  assign rf_rd_addr1 = rs1;
  assign rf_rd_addr2 = rs2;

`ifdef ID_BYPASS_EN
  assign rs1_val = (rs1 == '0) ? '0 :
                   (wb_wr_en && wb_wr_addr == rs1) ? wb_wr_data : rf_rd_data1;
  assign rs2_val = (rs2 == '0) ? '0 :
                   (wb_wr_en && wb_wr_addr == rs2) ? wb_wr_data : rf_rd_data2;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_wr_en, wb_wr_addr, wb_wr_data};
  assign rs1_val   = (rs1 == '0) ? '0 : rf_rd_data1;
  assign rs2_val   = (rs2 == '0) ? '0 : rf_rd_data2;
`endif

  imm_gen u_imm_gen (
    .instr (if_instr),
    .imm   (imm)
  );

  // Only source fields the opcode actually reads can create a load-use stall.
  assign hazard = valid_q && payload_q.is_load && (payload_q.rd != '0) &&
                  ((uses_rs1(opcode) && payload_q.rd == rs1) ||
                   (uses_rs2(opcode) && payload_q.rd == rs2));

  assign id_ready = !hazard && (!valid_q || ex_ready);
  assign capture  = if_valid && id_ready;

  always_comb begin
    payload_d          = '0;
    payload_d.pc       = if_pc;
    payload_d.instr    = if_instr;
    payload_d.rs1_data = rs1_val;
    payload_d.rs2_data = rs2_val;
    payload_d.imm      = imm;
    payload_d.rs1      = rs1;
    payload_d.rs2      = rs2;
    payload_d.rd       = rd;
    payload_d.rd_we    = writes_rd(opcode) && (rd != '0);
    payload_d.is_load  = (opcode == OPC_LOAD);
  end

  // A stall with ex_ready high falls into the last branch and becomes the bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q   <= 1'b1;
      payload_q <= payload_d;
    end else if (!valid_q || ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = payload_q.pc;
  assign ex_instr    = payload_q.instr;
  assign ex_rs1_data = payload_q.rs1_data;
  assign ex_rs2_data = payload_q.rs2_data;
  assign ex_imm      = payload_q.imm;
  assign ex_rs1      = payload_q.rs1;
  assign ex_rs2      = payload_q.rs2;
  assign ex_rd       = payload_q.rd;
  assign ex_rd_we    = payload_q.rd_we;
  assign ex_is_load  = payload_q.is_load;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_id_stage: vector table + scoreboard bench for id_stage. Rev 1.0    |
// +----------------------------------------------------------------------+
module tb_id_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        rd_we;
    logic        is_load;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_load;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        id_ready;
  logic [4:0]  rf_rd_addr1;
  logic [4:0]  rf_rd_addr2;
  logic [31:0] rf_rd_data1;
  logic [31:0] rf_rd_data2;
  logic        wb_wr_en = 1'b0;
  logic [4:0]  wb_wr_addr = '0;
  logic [31:0] wb_wr_data = '0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b1;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_instr, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_rd_we, ex_is_load;

  logic [31:0] rf_m [32];
  exp_t        sb[$];
  vec_t        vecs [12];
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  // Register file model; x0 reads back garbage so the zero-forcing is visible.
  assign rf_rd_data1 = rf_m[rf_rd_addr1];
  assign rf_rd_data2 = rf_m[rf_rd_addr2];

  id_stage #(.AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2), .wb_wr_en(wb_wr_en),
    .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .ex_is_load(ex_is_load)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t mk_exp(input logic [31:0] instr, input logic [31:0] pc,
                                  input logic [31:0] imm, input logic we, input logic ld);
    exp_t e;
    e.pc       = pc;
    e.instr    = instr;
    e.rs1      = instr[19:15];
    e.rs2      = instr[24:20];
    e.rd       = instr[11:7];
    e.rs1_data = (instr[19:15] == 5'd0) ? 32'h0 : rf_m[instr[19:15]];
    e.rs2_data = (instr[24:20] == 5'd0) ? 32'h0 : rf_m[instr[24:20]];
    e.imm      = imm;
    e.rd_we    = we;
    e.is_load  = ld;
    return e;
  endfunction

  // Present an instruction until accepted, then push its expected ID/EX contents.
  task automatic issue_exp(input exp_t e);
    bit ok = 1'b0;
    if_instr = e.instr;
    if_pc    = e.pc;
    if_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (id_ready) begin
        sb.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("issue_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] imm, input logic we, input logic ld);
    issue_exp(mk_exp(instr, pc, imm, we, ld));
  endtask

  // Scoreboard: an ID/EX entry is consumed exactly when valid and ready meet.
  always @(negedge clk) begin
    if (!rst && ex_valid && ex_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_issue", ex_pc, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_instr", ex_instr, e.instr);
        chk("ex_rs1_data", ex_rs1_data, e.rs1_data);
        chk("ex_rs2_data", ex_rs2_data, e.rs2_data);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_regs", {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, e.rs1, e.rs2, e.rd});
        chk("ex_flags", {30'd0, ex_rd_we, ex_is_load}, {30'd0, e.rd_we, e.is_load});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'hA500_0000 | (i * 32'h0001_0101);
    rf_m[0] = 32'h5555_AAAA;
    rf_m[3] = 32'h0;

    vecs[0]  = '{32'hFFF00293, 32'h100, 32'hFFFF_FFFF, 1'b1, 1'b0}; // addi x5,x0,-1
    vecs[1]  = '{32'h00812303, 32'h104, 32'h0000_0008, 1'b1, 1'b1}; // lw x6,8(x2)
    vecs[2]  = '{32'hFE512E23, 32'h108, 32'hFFFF_FFFC, 1'b0, 1'b0}; // sw x5,-4(x2)
    vecs[3]  = '{32'hFE208CE3, 32'h10C, 32'hFFFF_FFF8, 1'b0, 1'b0}; // beq x1,x2,-8
    vecs[4]  = '{32'h12345537, 32'h110, 32'h1234_5000, 1'b1, 1'b0}; // lui x10
    vecs[5]  = '{32'h80000097, 32'h114, 32'h8000_0000, 1'b1, 1'b0}; // auipc x1
    vecs[6]  = '{32'hFFFFF0EF, 32'h118, 32'hFFFF_FFFE, 1'b1, 1'b0}; // jal x1,-2
    vecs[7]  = '{32'h0010006F, 32'h11C, 32'h0000_0800, 1'b0, 1'b0}; // jal x0,+2048
    vecs[8]  = '{32'h7FF08167, 32'h120, 32'h0000_07FF, 1'b1, 1'b0}; // jalr x2,2047(x1)
    vecs[9]  = '{32'h001303B3, 32'h124, 32'h0000_0000, 1'b1, 1'b0}; // add x7,x6,x1
    vecs[10] = '{32'hFFFFFFFF, 32'h128, 32'h0000_0000, 1'b0, 1'b0}; // unknown opcode
    vecs[11] = '{32'h00000013, 32'h12C, 32'h0000_0000, 1'b0, 1'b0}; // nop (rd=0)

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_id_ready", {31'd0, id_ready}, 32'd1);
    chk("reset_ex_zero", {31'd0, |{ex_pc, ex_instr, ex_rs1_data, ex_rs2_data, ex_imm,
                                   ex_rs1, ex_rs2, ex_rd, ex_rd_we, ex_is_load}}, 32'd0);

    if_instr = 32'h01F50A13;  // rs1=10, rs2=31, presented with if_valid low
    #1;
    chk("rf_rd_addr1", {27'd0, rf_rd_addr1}, 32'd10);
    chk("rf_rd_addr2", {27'd0, rf_rd_addr2}, 32'd31);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].instr, vecs[i].pc, vecs[i].imm, vecs[i].rd_we, vecs[i].is_load);
      @(posedge clk); #1;
    end

    // Load-use: LW x6 then ADD x7,x6,x1 -> one stall cycle, one bubble.
    issue(32'h00812303, 32'h200, 32'h8, 1'b1, 1'b1);
    if_instr = 32'h001303B3; if_pc = 32'h204; if_valid = 1'b1;
    @(negedge clk);
    chk("lu_stall_id_ready", {31'd0, id_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lu_bubble_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_resume_id_ready", {31'd0, id_ready}, 32'd1);
    sb.push_back(mk_exp(32'h001303B3, 32'h204, 32'h0, 1'b1, 1'b0));
    @(posedge clk); #1 if_valid = 1'b0;
    @(posedge clk); #1;

    // Back-pressure: ex_ready low for three cycles holds everything.
    ex_ready = 1'b0;
    issue(32'h12345537, 32'h300, 32'h1234_5000, 1'b1, 1'b0);
    if_instr = 32'h00500493; if_pc = 32'h304; if_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ex_valid", {31'd0, ex_valid}, 32'd1);
      chk("bp_id_ready", {31'd0, id_ready}, 32'd0);
      chk("bp_ex_pc", ex_pc, 32'h300);
      chk("bp_ex_imm", ex_imm, 32'h1234_5000);
      @(posedge clk); #1;
    end
    ex_ready = 1'b1;
    issue(32'h00500493, 32'h304, 32'h5, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Flush kills both the ID/EX entry and the instruction at the input.
    ex_ready = 1'b0;
    issue(32'h00100093, 32'h400, 32'h1, 1'b1, 1'b0);
    void'(sb.pop_back());
    if_instr = 32'h00200113; if_pc = 32'h404; if_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    ex_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_dropped", {31'd0, ex_valid}, 32'd0);
    @(posedge clk); #1;

    // Operand write-through from writeback.
    wb_wr_en = 1'b1; wb_wr_addr = 5'd3; wb_wr_data = 32'hDEAD_BEEF;
    e = mk_exp(32'h00018233, 32'h500, 32'h0, 1'b1, 1'b0);
`ifdef ID_BYPASS_EN
    e.rs1_data = 32'hDEAD_BEEF;
`else
    e.rs1_data = 32'h0;
`endif
    issue_exp(e);
    wb_wr_en = 1'b0; wb_wr_addr = '0; wb_wr_data = '0;
    @(posedge clk); #1;

    // Reset in the middle of a load-use stall.
    ex_ready = 1'b0;
    issue(32'h00812303, 32'h600, 32'h8, 1'b1, 1'b1);
    if_instr = 32'h001303B3; if_pc = 32'h604; if_valid = 1'b1;
    @(negedge clk);
    chk("rst_stall_id_ready", {31'd0, id_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; if_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("post_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("post_rst_id_ready", {31'd0, id_ready}, 32'd1);
    chk("post_rst_ex_zero", {31'd0, |{ex_pc, ex_instr, ex_rs1_data, ex_rs2_data, ex_imm,
                                      ex_rs1, ex_rs2, ex_rd, ex_rd_we, ex_is_load}}, 32'd0);
    ex_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
